bcd_display_scheduler: RTL and testbench

- Round-robin scheduler that shares one combinational BCD_Decoder (8-bit binary -> hundreds/tens/ones) between N_REQ value sources, e.g. PC, ACC, ALU result and switch input on the DE10 board.
- Grants one requester at a time, latches its value, registers the decoded digits for the 7-segment drivers, then holds them for a programmable dwell time before re-arbitrating.
- Sits between the CPU status taps and the HEX display encoders.

---
 rtl/bcd_sched_pkg.sv | 6 +
 rtl/BCD_Decoder.sv | 17 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/bcd_display_scheduler.sv | 106 ++++++++++
 tb/tb_bcd_display_scheduler.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared types and widths for the BCD display scheduler.
package bcd_sched_pkg;
   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned VAL_W   = 8;
endpackage

// File: rtl/BCD_Decoder.sv
// Combinational 8-bit binary to three-digit BCD decoder (000-255).
module BCD_Decoder
   import bcd_sched_pkg::*;
(
   input  logic [VAL_W-1:0]   i_bin,
   output logic [DIGIT_W-1:0] o_hundreds,
   output logic [DIGIT_W-1:0] o_tens,
   output logic [DIGIT_W-1:0] o_ones
);

   always_comb begin
      o_hundreds = DIGIT_W'(i_bin / 8'd100);
      o_tens     = DIGIT_W'((i_bin / 8'd10) % 8'd10);
      o_ones     = DIGIT_W'(i_bin % 8'd10);
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, wrapping.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant_onehot,
   output logic [PW-1:0] o_grant_idx,
   output logic          o_any
);

   int w_idx;

   always_comb begin
      w_idx       = 0;
      o_grant_idx = '0;
      o_any       = |i_req;
      // Scan from the farthest offset down so the nearest request wins.
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = (int'(i_ptr) + k) % N;
         if (i_req[w_idx]) o_grant_idx = PW'(w_idx);
      end
      o_grant_onehot = o_any ? (N'(1) << o_grant_idx) : '0;
   end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Shares one BCD decoder among N_REQ value sources, holding each display for a dwell time.
module bcd_display_scheduler
   import bcd_sched_pkg::*;
#(
   parameter  int N_REQ        = 4,
   parameter  int DWELL_CYCLES = 50_000_000,
   localparam int SRC_W        = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [VAL_W*N_REQ-1:0] value,
   output logic [N_REQ-1:0]       ack,
   output logic [DIGIT_W-1:0]     disp_hundreds,
   output logic [DIGIT_W-1:0]     disp_tens,
   output logic [DIGIT_W-1:0]     disp_ones,
   output logic [SRC_W-1:0]       disp_src,
   output logic                   disp_valid,
   output logic                   busy
);

   localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

   state_t             r_state;
   logic [SRC_W-1:0]   r_ptr;
   logic [SRC_W-1:0]   r_src;
   logic [CNT_W-1:0]   r_cnt;
   logic [VAL_W-1:0]   r_val;

   logic [N_REQ-1:0]   w_grant_onehot;
   logic [SRC_W-1:0]   w_grant_idx;
   logic               w_any;
   logic               w_do_grant;
   logic [DIGIT_W-1:0] w_hundreds;
   logic [DIGIT_W-1:0] w_tens;
   logic [DIGIT_W-1:0] w_ones;

   rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .i_req          (req),
      .i_ptr          (r_ptr),
      .o_grant_onehot (w_grant_onehot),
      .o_grant_idx    (w_grant_idx),
      .o_any          (w_any)
   );

   BCD_Decoder u_dec (
      .i_bin      (r_val),
      .o_hundreds (w_hundreds),
      .o_tens     (w_tens),
      .o_ones     (w_ones)
   );

   assign w_do_grant = w_any && ((r_state == IDLE) || ((r_state == HOLD) && (r_cnt == '0)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_ptr         <= '0;
         r_src         <= '0;
         r_cnt         <= '0;
         r_val         <= '0;
         ack           <= '0;
         disp_hundreds <= '0;
         disp_tens     <= '0;
         disp_ones     <= '0;
         disp_src      <= '0;
         disp_valid    <= 1'b0;
         busy          <= 1'b0;
      end else begin
         ack <= '0;
         if (w_do_grant) begin
            r_val   <= value[VAL_W*w_grant_idx +: VAL_W];
            r_src   <= w_grant_idx;
            ack     <= w_grant_onehot;
            r_ptr   <= (w_grant_idx == SRC_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            r_state <= CONV;
            busy    <= 1'b1;
         end else begin
            unique case (r_state)
               IDLE: begin
               end
               CONV: begin
                  disp_hundreds <= w_hundreds;
                  disp_tens     <= w_tens;
                  disp_ones     <= w_ones;
                  disp_src      <= r_src;
                  disp_valid    <= 1'b1;
                  r_cnt         <= CNT_W'(DWELL_CYCLES - 1);
                  r_state       <= HOLD;
               end
               HOLD: begin
                  if (r_cnt == '0) begin
                     r_state <= IDLE;
                     busy    <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed bench for bcd_display_scheduler with a short dwell of 4 cycles.
module tb_bcd_display_scheduler;

   localparam int N_REQ = 4;
   localparam int DWELL = 4;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] value;
   logic [3:0]  ack;
   logic [3:0]  disp_hundreds;
   logic [3:0]  disp_tens;
   logic [3:0]  disp_ones;
   logic [1:0]  disp_src;
   logic        disp_valid;
   logic        busy;

   int n_vec;
   int n_err;

   bcd_display_scheduler #(
      .N_REQ        (N_REQ),
      .DWELL_CYCLES (DWELL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .value         (value),
      .ack           (ack),
      .disp_hundreds (disp_hundreds),
      .disp_tens     (disp_tens),
      .disp_ones     (disp_ones),
      .disp_src      (disp_src),
      .disp_valid    (disp_valid),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ack"},    32'(ack), 32'h0);
      chk({tag, " digits"}, 32'({disp_hundreds, disp_tens, disp_ones}), 32'h0);
      chk({tag, " src"},    32'(disp_src), 32'h0);
      chk({tag, " valid"},  32'(disp_valid), 32'h0);
      chk({tag, " busy"},   32'(busy), 32'h0);
   endtask

   initial begin
      logic [3:0] exp_grant [5];
      logic [11:0] exp_digits [4];
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      req   = '0;
      value = '0;
      exp_grant[0] = 4'b0001;
      exp_grant[1] = 4'b0010;
      exp_grant[2] = 4'b0100;
      exp_grant[3] = 4'b1000;
      exp_grant[4] = 4'b0001;
      exp_digits[0] = 12'h000;
      exp_digits[1] = 12'h009;
      exp_digits[2] = 12'h100;
      exp_digits[3] = 12'h199;

      // Power-on reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_zero("reset");

      // Single request, value 255
      req = 4'b0100;
      value[23:16] = 8'd255;
      @(negedge clk);
      chk("ack src2", 32'(ack), 32'h4);
      chk("busy after grant", 32'(busy), 32'h1);
      req = 4'b0000;
      @(negedge clk);
      chk("ack one cycle", 32'(ack), 32'h0);
      chk("digits 255", 32'({disp_hundreds, disp_tens, disp_ones}), 32'h255);
      chk("src 2", 32'(disp_src), 32'h2);
      chk("valid", 32'(disp_valid), 32'h1);
      chk("busy in hold", 32'(busy), 32'h1);
      repeat (3) begin
         @(negedge clk);
         chk("busy still hold", 32'(busy), 32'h1);
      end
      @(negedge clk);
      chk("busy falls", 32'(busy), 32'h0);
      chk("retain 255 idle", 32'({disp_hundreds, disp_tens, disp_ones}), 32'h255);

      // Asynchronous reset pulse between edges
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("async reset");
      #1 rst = 1'b0;
      @(negedge clk);

      // Round robin with all requests held
      value = {8'd199, 8'd100, 8'd9, 8'd0};
      req   = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         chk("rr ack", 32'(ack), 32'(exp_grant[g]));
         @(negedge clk);
         chk("rr digits", 32'({disp_hundreds, disp_tens, disp_ones}),
             32'(exp_digits[g % 4]));
         chk("rr src", 32'(disp_src), 32'(g % 4));
         repeat (3) begin
            @(negedge clk);
            chk("rr no ack in hold", 32'(ack), 32'h0);
         end
         if (g == 4) req = 4'b0000;
      end
      repeat (2) @(negedge clk);
      chk("rr idle", 32'(busy), 32'h0);

      // Value changes after grant do not reach the display
      value[15:8] = 8'd42;
      req = 4'b0010;
      @(negedge clk);
      chk("ack src1", 32'(ack), 32'h2);
      value[15:8] = 8'd7;
      req = 4'b0000;
      repeat (4) begin
         @(negedge clk);
         chk("digits 042 held", 32'({disp_hundreds, disp_tens, disp_ones}), 32'h042);
      end
      @(negedge clk);

      // Reset during source 3 hold
      value[31:24] = 8'd123;
      req = 4'b1000;
      @(negedge clk);
      chk("ack src3", 32'(ack), 32'h8);
      req = 4'b0000;
      @(negedge clk);
      chk("digits 123", 32'({disp_hundreds, disp_tens, disp_ones}), 32'h123);
      chk("src 3", 32'(disp_src), 32'h3);
      #2 rst = 1'b1;
      req = 4'b0011;
      @(negedge clk);
      chk_zero("reset in hold");
      rst = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         chk("no ack3 after reset", 32'(ack[3]), 32'h0);
         if (c == 0) chk("post-reset grant 0", 32'(ack), 32'h1);
         if (c == 5) begin
            chk("post-reset grant 1", 32'(ack), 32'h2);
            req = 4'b0000;
         end
      end
      @(negedge clk);

      // Full value sweep on source 0
      for (int i = 0; i < 256; i++) begin
         value[7:0] = 8'(i);
         req = 4'b0001;
         @(negedge clk);
         req = 4'b0000;
         @(negedge clk);
         chk("sweep digits", 32'({disp_hundreds, disp_tens, disp_ones}),
             32'({4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)}));
         repeat (4) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      chk("idle retain 255", 32'({disp_hundreds, disp_tens, disp_ones}), 32'h255);
      chk("idle valid", 32'(disp_valid), 32'h1);
      chk("idle busy", 32'(busy), 32'h0);
      chk("idle src", 32'(disp_src), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
